// File: rtl/mem_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : mem_trace_monitor
// Brief    : Snoops the data-memory port and compares each access against
//            NUM_CH address windows. Matching reads and writes are pushed
//            into a first-word-fall-through trace FIFO, which is drained over
//            a valid/ready stream. The monitor only observes the bus and
//            never stalls the core.
// Revision : 1.0 - initial release
// ============================================================================
module mem_trace_monitor #(
    parameter int ADDR_WIDTH = 29,
    parameter int NUM_CH     = 4,
    parameter logic [NUM_CH*ADDR_WIDTH-1:0] CH_BASE = '0,
    parameter logic [NUM_CH*ADDR_WIDTH-1:0] CH_MASK = '0,
    parameter logic [2*NUM_CH-1:0]          CH_MODE = {NUM_CH{2'b01}},
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read_enable,
    input  logic [31:0]           read_data,
    input  logic                  write_enable,
    input  logic [31:0]           write_data,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [2:0]            trace_ch,
    output logic                  trace_is_rd,
    output logic [ADDR_WIDTH-1:0] trace_addr,
    output logic [31:0]           trace_data,
    output logic [TS_WIDTH-1:0]   trace_ts,
    output logic [15:0]           drop_count,
    output logic                  overflow,
    input  logic                  clear_drops
);

    localparam int c_PTR_W = $clog2(DEPTH);

    // ------------------------------------------------------------------------
    // Window compare: one hit per channel, qualified by the channel's mode
    // ------------------------------------------------------------------------
    logic [NUM_CH-1:0] w_wr_ok;
    logic [NUM_CH-1:0] w_rd_ok;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_addr_match;
        assign w_addr_match = (((address ^ CH_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])
                                & CH_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == '0);
        assign w_wr_ok[i]   = w_addr_match & CH_MODE[2*i];
        assign w_rd_ok[i]   = w_addr_match & CH_MODE[2*i+1];
    end

    logic       w_wr_hit;
    logic [2:0] w_wr_ch;
    logic       w_rd_hit;
    logic [2:0] w_rd_ch;

    // Priority encode the hits; scanning downwards lets the lowest index win
    always_comb begin
        w_wr_hit = 1'b0;
        w_wr_ch  = 3'd0;
        w_rd_hit = 1'b0;
        w_rd_ch  = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_wr_ok[i]) begin
                w_wr_hit = 1'b1;
                w_wr_ch  = 3'(i);
            end
            if (w_rd_ok[i]) begin
                w_rd_hit = 1'b1;
                w_rd_ch  = 3'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Timestamp
    // ------------------------------------------------------------------------
    logic [TS_WIDTH-1:0] r_ts;

    // Free-running timestamp, wraps naturally at all-ones
    always_ff @(posedge clock) begin
        if (reset) r_ts <= '0;
        else       r_ts <= r_ts + 1'b1;
    end

    // ------------------------------------------------------------------------
    // Read pending register: read data arrives one cycle after the strobe,
    // so channel, address and timestamp are held until then.
    // ------------------------------------------------------------------------
    logic                  w_wr_push;
    logic                  w_rd_latch;
    logic                  r_pend_valid;
    logic [2:0]            r_pend_ch;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [TS_WIDTH-1:0]   r_pend_ts;

    // A simultaneous write masks the read strobe entirely
    assign w_wr_push  = enable & write_enable & w_wr_hit;
    assign w_rd_latch = enable & read_enable & ~write_enable & w_rd_hit;

    // Capture the read descriptor; completion does not depend on enable
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_ch    <= 3'd0;
            r_pend_addr  <= '0;
            r_pend_ts    <= '0;
        end else begin
            r_pend_valid <= w_rd_latch;
            if (w_rd_latch) begin
                r_pend_ch   <= w_rd_ch;
                r_pend_addr <= address;
                r_pend_ts   <= r_ts;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Push arbitration: a new write beats a completing read
    // ------------------------------------------------------------------------
    logic                  w_push;
    logic                  w_collide;
    logic [2:0]            w_in_ch;
    logic                  w_in_is_rd;
    logic [ADDR_WIDTH-1:0] w_in_addr;
    logic [31:0]           w_in_data;
    logic [TS_WIDTH-1:0]   w_in_ts;

    assign w_push    = w_wr_push | r_pend_valid;
    assign w_collide = w_wr_push & r_pend_valid;

    // Select the entry to be pushed this cycle
    always_comb begin
        w_in_ch    = r_pend_ch;
        w_in_is_rd = 1'b1;
        w_in_addr  = r_pend_addr;
        w_in_data  = read_data;
        w_in_ts    = r_pend_ts;
        if (w_wr_push) begin
            w_in_ch    = w_wr_ch;
            w_in_is_rd = 1'b0;
            w_in_addr  = address;
            w_in_data  = write_data;
            w_in_ts    = r_ts;
        end
    end

    // ------------------------------------------------------------------------
    // Trace FIFO (extra pointer bit distinguishes full from empty)
    // ------------------------------------------------------------------------
    logic [c_PTR_W:0]      r_wr_ptr;
    logic [c_PTR_W:0]      r_rd_ptr;
    logic [2:0]            r_mem_ch    [DEPTH];
    logic                  r_mem_is_rd [DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_addr  [DEPTH];
    logic [31:0]           r_mem_data  [DEPTH];
    logic [TS_WIDTH-1:0]   r_mem_ts    [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_ok;
    logic w_full_drop;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic [c_PTR_W-1:0] w_rd_idx;

    assign w_wr_idx    = r_wr_ptr[c_PTR_W-1:0];
    assign w_rd_idx    = r_rd_ptr[c_PTR_W-1:0];
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) && (w_wr_idx == w_rd_idx);
    assign w_pop       = ~w_empty & trace_ready;
    // When full, a same-cycle pop frees the head slot so the push still fits
    assign w_push_ok   = w_push & (~w_full | w_pop);
    assign w_full_drop = w_push & w_full & ~w_pop;

    // Pointer update; reset discards every queued entry
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are only exposed while the FIFO is non-empty
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem_ch[w_wr_idx]    <= w_in_ch;
            r_mem_is_rd[w_wr_idx] <= w_in_is_rd;
            r_mem_addr[w_wr_idx]  <= w_in_addr;
            r_mem_data[w_wr_idx]  <= w_in_data;
            r_mem_ts[w_wr_idx]    <= w_in_ts;
        end
    end

    assign trace_valid = ~w_empty;
    assign trace_ch    = trace_valid ? r_mem_ch[w_rd_idx]    : 3'd0;
    assign trace_is_rd = trace_valid ? r_mem_is_rd[w_rd_idx] : 1'b0;
    assign trace_addr  = trace_valid ? r_mem_addr[w_rd_idx]  : '0;
    assign trace_data  = trace_valid ? r_mem_data[w_rd_idx]  : 32'd0;
    assign trace_ts    = trace_valid ? r_mem_ts[w_rd_idx]    : '0;

    // ------------------------------------------------------------------------
    // Drop accounting: a cycle can lose both a collided read and a full push
    // ------------------------------------------------------------------------
    logic [15:0] r_drop_count;
    logic        r_overflow;
    logic [16:0] w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_count} + 17'(w_collide) + 17'(w_full_drop);

    // Saturating drop counter with sticky overflow; clear wins over a drop
    always_ff @(posedge clock) begin
        if (reset || clear_drops) begin
            r_drop_count <= 16'd0;
            r_overflow   <= 1'b0;
        end else if (w_collide || w_full_drop) begin
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            r_overflow   <= 1'b1;
        end
    end

    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mem_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_trace_monitor
// Brief    : Directed self-checking bench for mem_trace_monitor.
//            ch0: 0x01000000 exact, writes; ch1: 0x02000000 exact, reads;
//            ch2: 0x010000xx, reads and writes; ch3: off.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_trace_monitor;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [28:0] address;
    logic        read_enable;
    logic [31:0] read_data;
    logic        write_enable;
    logic [31:0] write_data;
    logic        trace_valid;
    logic        trace_ready;
    logic [2:0]  trace_ch;
    logic        trace_is_rd;
    logic [28:0] trace_addr;
    logic [31:0] trace_data;
    logic [15:0] trace_ts;
    logic [15:0] drop_count;
    logic        overflow;
    logic        clear_drops;

    int checks = 0;
    int errors = 0;
    logic [15:0] tb_ts;
    logic [15:0] exp_ts;

    mem_trace_monitor #(
        .ADDR_WIDTH (29),
        .NUM_CH     (4),
        .CH_BASE    ({29'h03000000, 29'h01000000, 29'h02000000, 29'h01000000}),
        .CH_MASK    ({29'h1FFFFFFF, 29'h1FFFFF00, 29'h1FFFFFFF, 29'h1FFFFFFF}),
        .CH_MODE    ({2'b00, 2'b11, 2'b10, 2'b01}),
        .DEPTH      (16),
        .TS_WIDTH   (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .address      (address),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .write_enable (write_enable),
        .write_data   (write_data),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_ch     (trace_ch),
        .trace_is_rd  (trace_is_rd),
        .trace_addr   (trace_addr),
        .trace_data   (trace_data),
        .trace_ts     (trace_ts),
        .drop_count   (drop_count),
        .overflow     (overflow),
        .clear_drops  (clear_drops)
    );

    always #5 clock = ~clock;

    // Reference timestamp: cleared by reset, +1 per clock
    always @(posedge clock) begin
        if (reset) tb_ts <= 16'd0;
        else       tb_ts <= tb_ts + 16'd1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pop_one();
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
    endtask

    task automatic do_write(input logic [28:0] a, input logic [31:0] d);
        address = a; write_data = d; write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", trace_valid); end
        checks++; if ({trace_ch, trace_is_rd, trace_addr, trace_data, trace_ts} !== '0) begin errors++; $display("FAIL rst_fields: got ch=%h addr=%h data=%h ts=%h want 0", trace_ch, trace_addr, trace_data, trace_ts); end
        checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_drops: got %0d/%b want 0/0", drop_count, overflow); end
    endtask

    task automatic test_write_capture();
        address = 29'h01000000; write_data = 32'hA5; write_enable = 1'b1;
        exp_ts = tb_ts;
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL wr_early: got %b want 0", trace_valid); end
        tick();
        write_enable = 1'b0;
        checks++; if (trace_valid !== 1'b1) begin errors++; $display("FAIL wr_valid: got %b want 1", trace_valid); end
        checks++; if (trace_ch !== 3'd0 || trace_is_rd !== 1'b0) begin errors++; $display("FAIL wr_ch: got ch=%0d rd=%b want 0/0", trace_ch, trace_is_rd); end
        checks++; if (trace_addr !== 29'h01000000 || trace_data !== 32'hA5) begin errors++; $display("FAIL wr_payload: got %h/%h want 01000000/000000a5", trace_addr, trace_data); end
        checks++; if (trace_ts !== exp_ts) begin errors++; $display("FAIL wr_ts: got %h want %h", trace_ts, exp_ts); end
        pop_one();
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL wr_popped: got %b want 0", trace_valid); end
    endtask

    task automatic test_read_capture();
        address = 29'h02000000; read_enable = 1'b1;
        exp_ts = tb_ts;
        tick();
        read_enable = 1'b0; read_data = 32'h1234;
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL rd_pending: got %b want 0", trace_valid); end
        tick();
        read_data = 32'h0;
        checks++; if (trace_valid !== 1'b1 || trace_is_rd !== 1'b1 || trace_ch !== 3'd1) begin errors++; $display("FAIL rd_entry: got v=%b rd=%b ch=%0d want 1/1/1", trace_valid, trace_is_rd, trace_ch); end
        checks++; if (trace_data !== 32'h1234 || trace_addr !== 29'h02000000) begin errors++; $display("FAIL rd_payload: got %h/%h want 02000000/00001234", trace_addr, trace_data); end
        checks++; if (trace_ts !== exp_ts) begin errors++; $display("FAIL rd_ts: got %h want %h", trace_ts, exp_ts); end
        pop_one();
        // Pending read completes even after enable drops
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0; enable = 1'b0; read_data = 32'hBEEF;
        tick();
        enable = 1'b1; read_data = 32'h0;
        checks++; if (trace_valid !== 1'b1 || trace_data !== 32'hBEEF) begin errors++; $display("FAIL rd_en_off: got v=%b data=%h want 1/0000beef", trace_valid, trace_data); end
        pop_one();
        // Disabled capture records nothing
        enable = 1'b0;
        do_write(29'h01000000, 32'h11);
        enable = 1'b1;
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL disabled_wr: got %b want 0", trace_valid); end
    endtask

    task automatic test_overlap();
        do_write(29'h01000000, 32'h33);
        checks++; if (trace_ch !== 3'd0 || trace_data !== 32'h33) begin errors++; $display("FAIL ovl_ch: got ch=%0d data=%h want 0/33", trace_ch, trace_data); end
        pop_one();
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL ovl_single: got %b want 0", trace_valid); end
        do_write(29'h01000010, 32'h44);
        checks++; if (trace_valid !== 1'b1 || trace_ch !== 3'd2) begin errors++; $display("FAIL ovl_ch2: got v=%b ch=%0d want 1/2", trace_valid, trace_ch); end
        pop_one();
        do_write(29'h03000000, 32'h55);
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL ch_off: got %b want 0", trace_valid); end
    endtask

    task automatic test_overflow();
        trace_ready = 1'b0;
        for (int i = 0; i < 18; i++) do_write(29'h01000000, 32'h100 + i);
        checks++; if (drop_count !== 16'd2 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_drops: got %0d/%b want 2/1", drop_count, overflow); end
        checks++; if (trace_valid !== 1'b1 || trace_data !== 32'h100) begin errors++; $display("FAIL ovf_head: got v=%b data=%h want 1/100", trace_valid, trace_data); end
        clear_drops = 1'b1;
        tick();
        clear_drops = 1'b0;
        checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0d/%b want 0/0", drop_count, overflow); end
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (trace_valid !== 1'b1 || trace_data !== 32'h100 + i) begin errors++; $display("FAIL ovf_drain[%0d]: got v=%b data=%h want 1/%h", i, trace_valid, trace_data, 32'h100 + i); end
            tick();
        end
        trace_ready = 1'b0;
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", trace_valid); end
    endtask

    task automatic test_collision();
        address = 29'h01000020; read_enable = 1'b1;
        tick();
        read_enable = 1'b0; read_data = 32'h77;
        do_write(29'h01000000, 32'h55);
        read_data = 32'h0;
        checks++; if (trace_valid !== 1'b1 || trace_is_rd !== 1'b0 || trace_data !== 32'h55) begin errors++; $display("FAIL col_entry: got v=%b rd=%b data=%h want 1/0/55", trace_valid, trace_is_rd, trace_data); end
        checks++; if (drop_count !== 16'd1 || overflow !== 1'b1) begin errors++; $display("FAIL col_drop: got %0d/%b want 1/1", drop_count, overflow); end
        pop_one();
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL col_onlyone: got %b want 0", trace_valid); end
        clear_drops = 1'b1;
        tick();
        clear_drops = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) do_write(29'h01000000, 32'h200 + i);
        // Full FIFO: pop and push in the same cycle
        trace_ready = 1'b1;
        do_write(29'h01000000, 32'h2FF);
        checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL b2b_nodrop: got %0d/%b want 0/0", drop_count, overflow); end
        for (int i = 1; i < 16; i++) begin
            checks++; if (trace_valid !== 1'b1 || trace_data !== 32'h200 + i) begin errors++; $display("FAIL b2b_drain[%0d]: got v=%b data=%h want 1/%h", i, trace_valid, trace_data, 32'h200 + i); end
            tick();
        end
        checks++; if (trace_valid !== 1'b1 || trace_data !== 32'h2FF) begin errors++; $display("FAIL b2b_last: got v=%b data=%h want 1/2ff", trace_valid, trace_data); end
        tick();
        trace_ready = 1'b0;
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", trace_valid); end
    endtask

    task automatic test_reset_mid_drain();
        // One collision drop plus five queued entries
        address = 29'h01000020; read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        do_write(29'h01000000, 32'h60);
        for (int i = 1; i < 5; i++) do_write(29'h01000000, 32'h60 + i);
        checks++; if (trace_valid !== 1'b1 || drop_count !== 16'd1) begin errors++; $display("FAIL rmd_pre: got v=%b drops=%0d want 1/1", trace_valid, drop_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (trace_valid !== 1'b0 || drop_count !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rmd_cleared: got v=%b drops=%0d ovf=%b want 0/0/0", trace_valid, drop_count, overflow); end
        do_write(29'h01000000, 32'h66);
        checks++; if (trace_valid !== 1'b1 || trace_ts !== 16'd0 || trace_data !== 32'h66) begin errors++; $display("FAIL rmd_ts: got v=%b ts=%h data=%h want 1/0000/66", trace_valid, trace_ts, trace_data); end
        pop_one();
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL rmd_empty: got %b want 0", trace_valid); end
    endtask

    initial begin
        clock = 1'b0; reset = 1'b1; enable = 1'b1; address = '0;
        read_enable = 1'b0; read_data = '0; write_enable = 1'b0; write_data = '0;
        trace_ready = 1'b0; clear_drops = 1'b0;
        test_reset();
        test_write_capture();
        test_read_capture();
        test_overlap();
        test_overflow();
        test_collision();
        test_back_to_back();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
